// File: rtl/pulse_rx_multi_if.sv
// Signal bundle between the foreign-domain event sources and the pulse_rx_multi
// receiver; the master side drives toggles and acks, the slave side is the receiver.
interface pulse_rx_multi_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic [CH-1:0]       a_tog;
    logic [CH-1:0]       b_pul;
    logic [CH-1:0]       b_pend;
    logic [CH-1:0]       b_ack;
    logic [CH-1:0]       b_ovf;
    logic [CH*CNT_W-1:0] b_cnt;
    logic                b_cnt_clr;
    logic                b_armed;

    modport master (
        output a_tog, b_ack, b_cnt_clr,
        input  b_pul, b_pend, b_ovf, b_cnt, b_armed
    );

    modport slave (
        input  a_tog, b_ack, b_cnt_clr,
        output b_pul, b_pend, b_ovf, b_cnt, b_armed
    );
endinterface

// File: rtl/pulse_rx_multi.sv
// Multi-channel toggle-to-pulse synchroniser for the clkb domain, with post-reset
// arming, per-channel pending/overrun flags and saturating event counters.
module pulse_rx_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clkb,
    input  logic              rstnb,
    pulse_rx_multi_if.slave   bus
);

    localparam int                ARM_W    = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(SYNC_STAGES);

    typedef enum logic {
        UNARMED = 1'b0,
        ARMED   = 1'b1
    } arm_state_e;

    logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
    logic [CH-1:0]                  prev_q;

    arm_state_e        state_q, state_d;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [CH-1:0]     ev;

    logic [CH-1:0]              pul_q;
    logic [CH-1:0]              pend_q, pend_d;
    logic [CH-1:0]              ovf_q, ovf_d;
    logic [CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;

    // NOTE: the sync flops sit in the async reset too, so a mid-run reset drops in-flight toggles.
    always_ff @(posedge clkb or negedge rstnb) begin
        if (!rstnb) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.a_tog};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Arming holds off detection until prev has caught up with a line that was high through reset.
    // NOTE: every always_comb output gets a default first so no branch can infer a latch.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        ev        = '0;
        case (state_q)
            UNARMED: begin
                if (arm_cnt_q == ARM_LAST) state_d = ARMED;
                else                       arm_cnt_d = arm_cnt_q + 1'b1;
            end
            ARMED:   ev = sync_q[SYNC_STAGES-1] ^ prev_q;
            default: state_d = UNARMED;
        endcase
    end

    // Set beats clear on pend and ovf; a clear together with a pulse restarts the count at 1.
    always_comb begin
        pend_d = (pend_q & ~bus.b_ack) | pul_q;
        ovf_d  = (bus.b_cnt_clr ? '0 : ovf_q) | (pul_q & pend_q & ~bus.b_ack);
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.b_cnt_clr)
                cnt_d[i] = pul_q[i] ? CNT_W'(1) : '0;
            else if (pul_q[i] && (cnt_q[i] != '1))
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clkb or negedge rstnb) begin
        if (!rstnb) begin
            state_q   <= UNARMED;
            arm_cnt_q <= '0;
            pul_q     <= '0;
            pend_q    <= '0;
            ovf_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            pul_q     <= ev;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.b_pul   = pul_q;
    assign bus.b_pend  = pend_q;
    assign bus.b_ovf   = ovf_q;
    assign bus.b_cnt   = cnt_q;
    assign bus.b_armed = (state_q == ARMED);

endmodule

// File: tb/tb_pulse_rx_multi.sv
// Self-checking bench for pulse_rx_multi: directed scenarios then random toggles,
// compared every cycle against an event-schedule reference model.
module tb_pulse_rx_multi;

    localparam int CH      = 4;
    localparam int SS      = 2;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clkb  = 1'b0;
    logic rstnb = 1'b1;

    always #15 clkb = ~clkb;

    pulse_rx_multi_if #(.CH(CH), .CNT_W(CW)) bus ();

    pulse_rx_multi #(.CH(CH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clkb  (clkb),
        .rstnb (rstnb),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc     = 0;
    int rel_cyc = 0;
    bit in_reset = 1'b1;

    // Model: ring holds the set of channels expected to pulse at a given cycle.
    logic [CH-1:0] ring [8];
    logic [CH-1:0] m_pend;
    logic [CH-1:0] m_ovf;
    int            m_cnt [CH];
    int            last_tog [CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) ring[i] = '0;
        m_pend = '0;
        m_ovf  = '0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    endtask

    // One clkb cycle: compare outputs after the edge, advance the model, drive next inputs.
    task automatic step(input logic [CH-1:0] tog, input logic [CH-1:0] ack, input logic clr);
        logic [CH-1:0] p;
        logic          exp_armed;
        @(posedge clkb);
        cyc++;
        @(negedge clkb);
        p = ring[cyc % 8];
        ring[cyc % 8] = '0;
        exp_armed = !in_reset && ((cyc - rel_cyc) >= SS + 1);
        check("pul", bus.b_pul, p);
        check("pend", bus.b_pend, m_pend);
        check("ovf", bus.b_ovf, m_ovf);
        check("armed", bus.b_armed, exp_armed);
        for (int i = 0; i < CH; i++)
            check($sformatf("cnt%0d", i), bus.b_cnt[i*CW +: CW], m_cnt[i]);
        if (!in_reset) begin
            for (int i = 0; i < CH; i++) begin
                logic ovf_hit;
                ovf_hit   = p[i] && m_pend[i] && !ack[i];
                m_ovf[i]  = (clr ? 1'b0 : m_ovf[i]) | ovf_hit;
                m_pend[i] = p[i] | (m_pend[i] & ~ack[i]);
                if (clr)       m_cnt[i] = p[i] ? 1 : 0;
                else if (p[i]) m_cnt[i] = (m_cnt[i] >= CNT_MAX) ? CNT_MAX : m_cnt[i] + 1;
            end
            ring[(cyc + SS + 1) % 8] = ring[(cyc + SS + 1) % 8] | tog;
        end
        bus.a_tog     = bus.a_tog ^ tog;
        bus.b_ack     = ack;
        bus.b_cnt_clr = clr;
    endtask

    task automatic do_reset(input logic [CH-1:0] tog_level);
        rstnb = 1'b0;
        #1;
        check("armed_at_reset", bus.b_armed, 1'b0);
        check("pul_at_reset", bus.b_pul, '0);
        in_reset      = 1'b1;
        model_clear();
        bus.a_tog     = tog_level;
        bus.b_ack     = '0;
        bus.b_cnt_clr = 1'b0;
        repeat (2) step('0, '0, 1'b0);
        rstnb    = 1'b1;
        in_reset = 1'b0;
        rel_cyc  = cyc;
    endtask

    initial begin
        bus.a_tog     = '0;
        bus.b_ack     = '0;
        bus.b_cnt_clr = 1'b0;
        model_clear();
        for (int i = 0; i < CH; i++) last_tog[i] = -100;
        @(negedge clkb);

        // Lines 0 and 2 high through reset must not pulse once armed.
        do_reset(4'b0101);
        repeat (2) step('0, '0, 1'b0);
        check("armed_after_2", bus.b_armed, 1'b0);
        step('0, '0, 1'b0);
        check("armed_after_3", bus.b_armed, 1'b1);
        repeat (4) step('0, '0, 1'b0);

        // Single toggle on channel 1.
        step(4'b0010, '0, 1'b0);
        repeat (3) step('0, '0, 1'b0);
        check("ch1_pul", bus.b_pul[1], 1'b1);
        step('0, '0, 1'b0);
        check("ch1_pul_one_cycle", bus.b_pul[1], 1'b0);
        check("ch1_pend", bus.b_pend[1], 1'b1);
        check("ch1_cnt", bus.b_cnt[1*CW +: CW], 1);

        // Seventeen unacked events on channel 2 saturate its counter.
        repeat (17) begin
            step(4'b0100, '0, 1'b0);
            repeat (9) step('0, '0, 1'b0);
        end
        check("ch2_sat", bus.b_cnt[2*CW +: CW], CNT_MAX);
        check("ch2_ovf", bus.b_ovf[2], 1'b1);
        check("ch2_pend", bus.b_pend[2], 1'b1);

        // Channel 0: ack in the pulse cycle loses to the set and blocks overrun.
        step(4'b0001, '0, 1'b0);
        repeat (5) step('0, '0, 1'b0);
        step(4'b0001, '0, 1'b0);
        repeat (2) step('0, '0, 1'b0);
        step('0, 4'b0001, 1'b0);
        step('0, 4'b0001, 1'b0);
        check("ch0_pend_set_wins", bus.b_pend[0], 1'b1);
        check("ch0_no_ovf", bus.b_ovf[0], 1'b0);
        step('0, '0, 1'b0);
        check("ch0_pend_cleared", bus.b_pend[0], 1'b0);

        // All channels at once with a counter clear in the pulse cycle.
        repeat (2) step('0, 4'hF, 1'b0);
        step(4'hF, '0, 1'b0);
        repeat (2) step('0, '0, 1'b0);
        step('0, '0, 1'b1);
        check("all_pul", bus.b_pul, 4'hF);
        step('0, '0, 1'b0);
        for (int i = 0; i < CH; i++)
            check($sformatf("clr_cnt%0d", i), bus.b_cnt[i*CW +: CW], 1);
        check("clr_ovf", bus.b_ovf, 4'h0);

        // Reset one cycle after a channel 3 toggle drops the event.
        step(4'b1000, '0, 1'b0);
        step('0, '0, 1'b0);
        do_reset(bus.a_tog);
        repeat (3) step('0, '0, 1'b0);
        check("rearmed", bus.b_armed, 1'b1);
        repeat (5) step('0, '0, 1'b0);

        // Random toggles (spaced at least 2 cycles per channel), acks and clears.
        repeat (400) begin
            logic [CH-1:0] tog;
            logic [CH-1:0] ack;
            logic          clr;
            tog = '0;
            for (int i = 0; i < CH; i++) begin
                if ((cyc - last_tog[i]) >= 2 && $urandom_range(0, 2) == 0) begin
                    tog[i]      = 1'b1;
                    last_tog[i] = cyc;
                end
            end
            ack = CH'($urandom) & CH'($urandom);
            clr = ($urandom_range(0, 19) == 0);
            step(tog, ack, clr);
        end
        repeat (6) step('0, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pulse_rx_multi.md
# pulse_rx_multi

Multi-channel, parametrised receive-side pulse synchroniser. It runs in the destination clock domain. It accepts CH toggle-encoded event lines from a foreign domain and synchronises each through a SYNC_STAGES flop chain. It emits one single-cycle pulse per toggle, and keeps a per-channel pending flag, a missed-service flag and a saturating event counter. It replaces single-channel pulse synchronisation at the destination side of every CDC event path and adds multi-channel support, post-reset arming, event bookkeeping and overrun detection.

## Interface
- CH, 4: number of independent event channels (1..32).
- SYNC_STAGES, 2: synchroniser depth per channel (2..4).
- CNT_W, 8: width of each per-channel event counter (2..16).
- clkb  input  1  destination clock; the only clock of the block; all logic on its rising edge.
- rstnb  input  1  reset; asynchronous assertion, active-low.
- a_tog  input  CH  toggle lines from the source domain; one level change = one event; asynchronous to clkb.
- b_pul  output  CH  registered one-cycle pulse per detected toggle.
- b_pend  output  CH  sticky "event pending" flag per channel.
- b_ack  input  CH  per-channel clear of b_pend (level, sampled each cycle).
- b_ovf  output  CH  sticky overrun: an event arrived while b_pend was already set and not being acked.
- b_cnt  output  CH*CNT_W  packed per-channel saturating event counters; channel i is in bits [i*CNT_W +: CNT_W].
- b_cnt_clr  input  1  synchronous clear of all counters and all b_ovf bits.
- b_armed  output  1  high once post-reset arming is complete.

## Operation
- Synchroniser: a_tog[i] passes through SYNC_STAGES flops and then one history flop (prev). The sync flops and prev reset to 0.
- Arming FSM, two states:
  - UNARMED: entered on reset. A counter counts SYNC_STAGES+1 clkb edges. prev copies the last sync stage every cycle. No events are detected. b_armed=0. Transition to ARMED when the count completes.
  - ARMED: terminal until the next reset. b_armed=1. Event detect ev[i] = sync_last[i] ^ prev[i]. prev keeps tracking.
  - Effect: a toggle line that sits at 1 across reset never produces a spurious pulse.
- b_pul[i] registers ev[i] and is high for exactly one cycle per event.
- b_pend[i]: set when b_pul[i] is high; cleared when b_ack[i] is high. If both happen in the same cycle, set wins. Acking an idle flag has no effect.
- b_ovf[i]: set when b_pul[i] is high while b_pend[i]=1 and b_ack[i]=0. Cleared only by b_cnt_clr or reset.
- Counter i:
  - Increments on b_pul[i] and saturates at 2^CNT_W-1; it never wraps.
  - b_cnt_clr alone loads 0.
  - b_cnt_clr together with b_pul[i] loads 1.
  - b_cnt_clr together with b_pul[i] and an ovf condition: b_ovf[i] ends at 1, because set wins.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Reset mid-operation: all state clears immediately, including in-flight sync bits. The arming sequence restarts. Events in flight are dropped.

## Timing
- Reset values: b_pul=0, b_pend=0, b_ovf=0, b_cnt=0, b_armed=0.
- b_armed rises after the (SYNC_STAGES+1)th rising clkb edge following rstnb deassertion.
- Latency: a toggle captured by sync stage 1 at edge E0 gives b_pul high from edge E0+SYNC_STAGES to edge E0+SYNC_STAGES+1. With SYNC_STAGES=2 that is 3 edges.
- b_pend, b_cnt and b_ovf update on the edge after the b_pul edge, i.e. they reflect the event one cycle after b_pul rises.
- Source-side rule: consecutive toggles on one channel must be at least 2 clkb periods apart. A closer pair is indistinguishable from no event; this is not detected and is the source's responsibility.
- No combinational path from any input to any output.

## Test plan
All scenarios use CH=4, SYNC_STAGES=2, CNT_W=4, clkb period 30 ns.
- Reset with a_tog=4'b0101, release, hold inputs -> b_armed=1 after 3 edges; b_pul stays 0; b_pend=0; b_cnt all 0.
- After arming, toggle a_tog[1] once -> b_pul[1] high for exactly one cycle, 3 edges after capture; then b_pend[1]=1 and b_cnt ch1=1.
- Toggle a_tog[2] 17 times, 10 cycles apart, never ack -> b_cnt ch2 saturates at 15; b_ovf[2]=1 after the 2nd event; b_pend[2]=1.
- Toggle ch0 with b_ack[0] held high in the cycle b_pul[0] is high -> b_pend[0] stays 1 and b_ovf[0] stays 0. The next cycle with ack high clears b_pend[0].
- Toggle all 4 channels on the same edge while b_cnt_clr=1 at the pulse cycle -> b_pul=4'hF in one cycle; every counter=1; all b_ovf=0.
- Assert rstnb low in the cycle after a toggle on ch3 -> no b_pul[3] after release; b_armed drops to 0 and rises again after 3 edges.
